// File: rtl/sc_ifu.sv
// -----------------------------------------------------------------------------
// sc_ifu - instruction-fetch unit for the single-cycle MIPS core.
//
// Owns the program counter, fetches one word per instruction from an
// instruction memory with a variable-latency request/ack handshake, and
// holds the fetched word stable for the datapath until it commits. The
// next PC is formed from the control unit's pcsource selection.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   MAX_WAIT    FETCH cycles allowed without imem_ack before fetch_err (1..255)
//
// Ports
//   clock       in   1   rising-edge clock
//   resetn      in   1   asynchronous active-low reset
//   pcsource    in   2   00 pc+4, 01 branch, 10 jr, 11 j/jal
//   ra_data     in   32  rs register value (jr target)
//   commit      in   1   datapath finished current instruction (EXEC only)
//   imem_rdata  in   32  instruction word, valid with imem_ack
//   imem_ack    in   1   instruction memory response
//   imem_req    out  1   fetch request, level, held until ack
//   imem_addr   out  32  fetch address (= pc)
//   inst        out  32  latched instruction
//   inst_valid  out  1   inst valid and stable (EXEC)
//   pc          out  32  address of inst
//   pc4         out  32  pc + 4 (jal link value)
//   fetch_err   out  1   sticky: fetch timeout or misaligned next PC
// -----------------------------------------------------------------------------
module sc_ifu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [1:0]  pcsource,
   input  logic [31:0] ra_data,
   input  logic        commit,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   // Last wait count at which a missing ack is still tolerated.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic [7:0]  wait_q, wait_d;

   logic [31:0] pc4_w;
   logic [31:0] br_off_w;
   logic [31:0] npc_w;

   // --------------------------------------------------------------------------
   // Next-PC formation from the latched instruction (wraps modulo 2^32)
   // --------------------------------------------------------------------------
   assign pc4_w    = pc_q + 32'd4;
   assign br_off_w = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

   always_comb begin
      npc_w = pc4_w;
      unique case (pcsource)
         2'b00:   npc_w = pc4_w;
         2'b01:   npc_w = pc4_w + br_off_w;
         2'b10:   npc_w = ra_data;
         2'b11:   npc_w = {pc4_w[31:28], inst_q[25:0], 2'b00};
         default: npc_w = pc4_w;
      endcase
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      wait_d  = wait_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            // An ack on the final allowed edge still wins over the timeout.
            if (imem_ack) begin
               inst_d  = imem_rdata;
               wait_d  = '0;
               state_d = S_EXEC;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               wait_d  = wait_q + 8'd1;
            end
         end

         S_EXEC: begin
            if (commit) begin
               // Misaligned targets are still loaded into pc so the faulting
               // address is visible after the halt.
               pc_d = npc_w;
               if (npc_w[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs decoded from the registered state
   // --------------------------------------------------------------------------
   assign imem_req   = (state_q == S_FETCH);
   assign imem_addr  = pc_q;
   assign inst_valid = (state_q == S_EXEC);
   assign inst       = inst_q;
   assign pc         = pc_q;
   assign pc4        = pc4_w;
   assign fetch_err  = err_q;

endmodule

// File: tb/tb_sc_ifu.sv
module tb_sc_ifu;

   logic        clock;
   logic        resetn;
   logic [1:0]  pcsource;
   logic [31:0] ra_data;
   logic        commit;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        fetch_err;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   sc_ifu #(
      .RESET_PC (32'h0000_0000),
      .MAX_WAIT (4)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .pcsource   (pcsource),
      .ra_data    (ra_data),
      .commit     (commit),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .inst       (inst),
      .inst_valid (inst_valid),
      .pc         (pc),
      .pc4        (pc4),
      .fetch_err  (fetch_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Advance one cycle; inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clock);
   endtask

   // From FETCH: hold off ack for 'delay' cycles, then ack with 'word'.
   task automatic do_fetch(input logic [31:0] word, input int delay);
      for (int i = 0; i < delay; i++) tick();
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'hA5A5_A5A5;
   endtask

   // From EXEC: commit once with the given next-PC selection.
   task automatic do_commit(input logic [1:0] ps, input logic [31:0] ra);
      commit   = 1'b1;
      pcsource = ps;
      ra_data  = ra;
      tick();
      commit   = 1'b0;
      pcsource = 2'b00;
      ra_data  = 32'h0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick();   // IDLE -> FETCH
   endtask

   initial begin
      resetn     = 1'b0;
      pcsource   = 2'b00;
      ra_data    = 32'h0;
      commit     = 1'b0;
      imem_rdata = 32'h0;
      imem_ack   = 1'b0;

      // ---- reset state ----
      #12;
      check_eq("rst_req",   32'(imem_req),   32'h0);
      check_eq("rst_valid", 32'(inst_valid), 32'h0);
      check_eq("rst_pc",    pc,              32'h0);
      check_eq("rst_inst",  inst,            32'h0);
      check_eq("rst_err",   32'(fetch_err),  32'h0);
      check_eq("rst_pc4",   pc4,             32'h4);

      // ---- 1: sequential fetch ----
      tick();
      resetn = 1'b1;
      tick();
      check_eq("t1_req0",  32'(imem_req), 32'h1);
      check_eq("t1_addr0", imem_addr,     32'h0);
      do_fetch(32'h2008_0005, 1);
      check_eq("t1_valid", 32'(inst_valid), 32'h1);
      check_eq("t1_inst",  inst,            32'h2008_0005);
      check_eq("t1_noreq", 32'(imem_req),   32'h0);
      // Stray ack and changed rdata while in EXEC must not disturb inst.
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      check_eq("t1_hold",  inst,            32'h2008_0005);
      check_eq("t1_hold_v",32'(inst_valid), 32'h1);
      do_commit(2'b00, 32'h0);
      check_eq("t1_addr4", imem_addr,       32'h4);
      check_eq("t1_req1",  32'(imem_req),   32'h1);
      check_eq("t1_nv",    32'(inst_valid), 32'h0);

      // ---- 2: branches ----
      do_fetch(32'h0000_0008, 0);
      do_commit(2'b10, 32'h40);
      check_eq("t2_jr40", imem_addr, 32'h40);
      do_fetch(32'h1000_FFFF, 0);
      check_eq("t2_pc4",  pc4, 32'h44);
      do_commit(2'b01, 32'h0);
      check_eq("t2_bneg", imem_addr, 32'h40);
      do_fetch(32'h1000_0003, 0);
      do_commit(2'b01, 32'h0);
      check_eq("t2_bpos", imem_addr, 32'h50);

      // ---- 3: j / jr / misaligned jr ----
      do_fetch(32'h0000_0008, 0);
      do_commit(2'b10, 32'h1000_0008);
      check_eq("t3_pc", imem_addr, 32'h1000_0008);
      do_fetch(32'h0800_0010, 0);
      do_commit(2'b11, 32'h0);
      check_eq("t3_j",  imem_addr, 32'h1000_0040);
      do_fetch(32'h0000_0008, 1);
      do_commit(2'b10, 32'h200);
      check_eq("t3_jr", imem_addr, 32'h200);
      do_fetch(32'h0000_0008, 0);
      do_commit(2'b10, 32'h202);
      check_eq("t3_err",   32'(fetch_err),  32'h1);
      check_eq("t3_req",   32'(imem_req),   32'h0);
      check_eq("t3_nv",    32'(inst_valid), 32'h0);
      check_eq("t3_pcdbg", pc,              32'h202);
      commit = 1'b1; imem_ack = 1'b1;
      tick(); tick();
      commit = 1'b0; imem_ack = 1'b0;
      check_eq("t3_halt_req", 32'(imem_req),  32'h0);
      check_eq("t3_halt_err", 32'(fetch_err), 32'h1);
      check_eq("t3_halt_pc",  pc,             32'h202);
      check_eq("t3_halt_in",  inst,           32'h0000_0008);

      // ---- 4: fetch timeout with MAX_WAIT=4 ----
      do_reset();
      check_eq("t4_clr", 32'(fetch_err), 32'h0);
      do_fetch(32'h1234_5678, 3);     // ack on the 4th FETCH edge
      check_eq("t4_late_ok", 32'(fetch_err),  32'h0);
      check_eq("t4_late_v",  32'(inst_valid), 32'h1);
      do_commit(2'b00, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t4_wait_err", 32'(fetch_err), 32'h0);
         check_eq("t4_wait_req", 32'(imem_req),  32'h1);
      end
      tick();
      check_eq("t4_to_err", 32'(fetch_err), 32'h1);
      check_eq("t4_to_req", 32'(imem_req),  32'h0);
      tick();
      check_eq("t4_sticky", 32'(fetch_err), 32'h1);
      check_eq("t4_pc",     pc,             32'h4);

      // ---- 5: reset during FETCH, ack in IDLE ignored ----
      do_reset();
      do_fetch(32'h0000_0008, 0);
      do_commit(2'b10, 32'h80);
      check_eq("t5_pre_req", 32'(imem_req), 32'h1);
      #2 resetn = 1'b0;
      #1;
      check_eq("t5_async_req", 32'(imem_req), 32'h0);
      check_eq("t5_async_pc",  pc,            32'h0);
      tick();
      resetn = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      check_eq("t5_req",  32'(imem_req),   32'h1);
      check_eq("t5_addr", imem_addr,       32'h0);
      check_eq("t5_inst", inst,            32'h0);
      check_eq("t5_nv",   32'(inst_valid), 32'h0);

      // ---- 6: commit and ack held high ----
      commit = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0; pcsource = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t6_exec_v",  32'(inst_valid), 32'h1);
         check_eq("t6_exec_pc", pc,              32'(4 * i));
         tick();
         check_eq("t6_fet_v",    32'(inst_valid), 32'h0);
         check_eq("t6_fet_addr", imem_addr,       32'(4 * (i + 1)));
      end
      commit = 1'b0; imem_ack = 1'b0;
      do_fetch(32'h0000_0008, 0);
      do_commit(2'b10, 32'hFFFF_FFFC);
      check_eq("t6_top", imem_addr, 32'hFFFF_FFFC);
      do_fetch(32'h0000_0000, 0);
      check_eq("t6_pc4wrap", pc4, 32'h0);
      do_commit(2'b00, 32'h0);
      check_eq("t6_wrap", imem_addr, 32'h0);
      check_eq("t6_err",  32'(fetch_err), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
